// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit bus bundle: redirects, imem port, decode lanes
// master: fetch_unit side (drives imem_addr/imem_rmask, inst_valid/inst/inst_pc, fq_count)
// slave : environment side (drives redirects, imem_rdata/imem_resp, inst_ready)
interface fetch_unit_if #(
  parameter int SS       = 2,
  parameter int FQ_DEPTH = 8
);
  logic                          commit_redirect_valid;
  logic [31:0]                   commit_redirect_pc;
  logic                          decode_redirect_valid;
  logic [31:0]                   decode_redirect_pc;
  logic [31:0]                   imem_addr;
  logic [3:0]                    imem_rmask;
  logic [31:0]                   imem_rdata;
  logic                          imem_resp;
  logic [SS-1:0]                 inst_valid;
  logic [SS*32-1:0]              inst;
  logic [SS*32-1:0]              inst_pc;
  logic                          inst_ready;
  logic [$clog2(FQ_DEPTH):0]     fq_count;

  modport master (
    input  commit_redirect_valid, commit_redirect_pc,
    input  decode_redirect_valid, decode_redirect_pc,
    output imem_addr, imem_rmask,
    input  imem_rdata, imem_resp,
    output inst_valid, inst, inst_pc, fq_count,
    input  inst_ready
  );

  modport slave (
    output commit_redirect_valid, commit_redirect_pc,
    output decode_redirect_valid, decode_redirect_pc,
    input  imem_addr, imem_rmask,
    output imem_rdata, imem_resp,
    input  inst_valid, inst, inst_pc, fq_count,
    output inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with decoupling circular fetch queue
// clk, rst : clock, asynchronous active-high reset
// bus      : fetch_unit_if.master (redirect inputs, single-outstanding imem port,
//            SS head-first decode lanes with inst_ready, queue occupancy)
module fetch_unit #(
  parameter int          SS       = 2,
  parameter int          FQ_DEPTH = 8,
  parameter logic [31:0] RESET_PC = 32'h6000_0000
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  localparam int AW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);
  localparam logic [CW-1:0] SS_C    = CW'(SS);

  typedef enum logic [1:0] {IDLE, WAIT, STALE} state_t;

  state_t        state, state_next;
  logic [31:0]   fetch_pc;
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [31:0]   q_inst [FQ_DEPTH];
  logic [31:0]   q_pc   [FQ_DEPTH];

  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          issue;
  logic          enq;
  logic [CW-1:0] n_pop;

  always_comb begin
    redirect    = bus.commit_redirect_valid | bus.decode_redirect_valid;
    redirect_pc = bus.commit_redirect_valid ? bus.commit_redirect_pc : bus.decode_redirect_pc;
    // count<FQ_DEPTH reserves a slot for the single outstanding response
    issue       = (state == IDLE) && (count < DEPTH_C) && !redirect;
    enq         = (state == WAIT) && bus.imem_resp && !redirect;
    n_pop       = '0;
    if (bus.inst_ready && !redirect)
      n_pop = (count < SS_C) ? count : SS_C;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (issue) state_next = WAIT;
      // a redirect while waiting leaves an old-path response in flight
      WAIT: begin
        if (bus.imem_resp)  state_next = IDLE;
        else if (redirect)  state_next = STALE;
      end
      STALE:   if (bus.imem_resp) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      state <= state_next;
      if (redirect) begin
        fetch_pc <= redirect_pc;
        head     <= tail;
        count    <= '0;
      end else begin
        if (enq) begin
          fetch_pc <= fetch_pc + 32'd4;
          tail     <= tail + AW'(1);
        end
        head  <= head + n_pop[AW-1:0];
        count <= count + CW'(enq) - n_pop;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_inst[tail] <= bus.imem_rdata;
      q_pc[tail]   <= fetch_pc;
    end
  end

  always_comb begin
    bus.imem_addr  = fetch_pc;
    bus.imem_rmask = issue ? 4'hF : 4'h0;
    bus.fq_count   = count;
    for (int i = 0; i < SS; i++) begin
      bus.inst_valid[i]       = count > CW'(i);
      bus.inst[i*32 +: 32]    = q_inst[head + AW'(i)];
      bus.inst_pc[i*32 +: 32] = q_pc[head + AW'(i)];
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit (SS=2, FQ_DEPTH=8)
module tb_fetch_unit;
  localparam logic [31:0] XOR_K = 32'hA5A5_A5A5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if #(.SS(2), .FQ_DEPTH(8)) bus ();

  fetch_unit #(.SS(2), .FQ_DEPTH(8), .RESET_PC(32'h6000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    logic        crv;
    logic [31:0] cpc;
    logic        drv;
    logic [31:0] dpc;
    logic        resp;
    logic [31:0] rdata;
    logic        rdy;
    logic [3:0]  e_rmask;
    logic [31:0] e_addr;
    logic [3:0]  e_cnt;
    logic [1:0]  e_valid;
    logic [31:0] e_pc0;
    logic [31:0] e_inst0;
  } vec_t;

  vec_t        tv [23];
  int          checks   = 0;
  int          failures = 0;
  logic        pend     = 1'b0;
  logic [31:0] pend_addr = '0;

  function automatic vec_t mk(input logic crv, input logic [31:0] cpc,
                              input logic drv, input logic [31:0] dpc,
                              input logic resp, input logic [31:0] rdata, input logic rdy,
                              input logic [3:0] e_rmask, input logic [31:0] e_addr,
                              input logic [3:0] e_cnt, input logic [1:0] e_valid,
                              input logic [31:0] e_pc0, input logic [31:0] e_inst0);
    vec_t v;
    v.crv = crv; v.cpc = cpc; v.drv = drv; v.dpc = dpc;
    v.resp = resp; v.rdata = rdata; v.rdy = rdy;
    v.e_rmask = e_rmask; v.e_addr = e_addr; v.e_cnt = e_cnt;
    v.e_valid = e_valid; v.e_pc0 = e_pc0; v.e_inst0 = e_inst0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle with an auto-responder answering each request one cycle later.
  task automatic step_auto(input logic rdy);
    @(negedge clk);
    bus.commit_redirect_valid = 1'b0;
    bus.decode_redirect_valid = 1'b0;
    bus.imem_resp  = pend;
    bus.imem_rdata = pend ? (pend_addr ^ XOR_K) : 32'h0;
    bus.inst_ready = rdy;
    #1;
    pend      = (bus.imem_rmask == 4'hF);
    pend_addr = bus.imem_addr;
  endtask

  initial begin
    int          issues_full;
    int          bad_contig;
    int          consumed;
    int          npop;
    logic [31:0] exp_pc;

    bus.commit_redirect_valid = 1'b0;
    bus.commit_redirect_pc    = '0;
    bus.decode_redirect_valid = 1'b0;
    bus.decode_redirect_pc    = '0;
    bus.imem_rdata            = '0;
    bus.imem_resp             = 1'b0;
    bus.inst_ready            = 1'b0;

    //           crv cpc            drv dpc            rsp rdata         rdy  rmask addr          cnt valid  pc0            inst0
    tv[0]  = mk(0, 0,             0, 0,             0, 0,            0,   4'hF, 32'h6000_0000, 0, 2'b00, 0,             0);
    tv[1]  = mk(0, 0,             0, 0,             0, 0,            0,   4'h0, 32'h6000_0000, 0, 2'b00, 0,             0);
    tv[2]  = mk(0, 0,             0, 0,             1, 32'h1111_1111,0,   4'h0, 32'h6000_0000, 0, 2'b00, 0,             0);
    tv[3]  = mk(0, 0,             0, 0,             0, 0,            0,   4'hF, 32'h6000_0004, 1, 2'b01, 32'h6000_0000, 32'h1111_1111);
    tv[4]  = mk(0, 0,             0, 0,             0, 0,            0,   4'h0, 32'h6000_0004, 1, 2'b01, 32'h6000_0000, 32'h1111_1111);
    tv[5]  = mk(0, 0,             0, 0,             1, 32'h2222_2222,0,   4'h0, 32'h6000_0004, 1, 2'b01, 32'h6000_0000, 32'h1111_1111);
    tv[6]  = mk(0, 0,             0, 0,             0, 0,            0,   4'hF, 32'h6000_0008, 2, 2'b11, 32'h6000_0000, 32'h1111_1111);
    tv[7]  = mk(0, 0,             0, 0,             0, 0,            0,   4'h0, 32'h6000_0008, 2, 2'b11, 32'h6000_0000, 32'h1111_1111);
    tv[8]  = mk(0, 0,             0, 0,             1, 32'h3333_3333,0,   4'h0, 32'h6000_0008, 2, 2'b11, 32'h6000_0000, 32'h1111_1111);
    tv[9]  = mk(0, 0,             0, 0,             0, 0,            1,   4'hF, 32'h6000_000C, 3, 2'b11, 32'h6000_0000, 32'h1111_1111);
    tv[10] = mk(0, 0,             1, 32'h6000_0100, 0, 0,            0,   4'h0, 32'h6000_000C, 1, 2'b01, 32'h6000_0008, 32'h3333_3333);
    tv[11] = mk(0, 0,             0, 0,             0, 0,            0,   4'h0, 32'h6000_0100, 0, 2'b00, 0,             0);
    tv[12] = mk(0, 0,             0, 0,             0, 0,            0,   4'h0, 32'h6000_0100, 0, 2'b00, 0,             0);
    tv[13] = mk(0, 0,             0, 0,             1, 32'hDEAD_BEEF,0,   4'h0, 32'h6000_0100, 0, 2'b00, 0,             0);
    tv[14] = mk(0, 0,             0, 0,             0, 0,            0,   4'hF, 32'h6000_0100, 0, 2'b00, 0,             0);
    tv[15] = mk(1, 32'h6000_0200, 1, 32'h6000_0300, 1, 32'h4444_4444,0,   4'h0, 32'h6000_0100, 0, 2'b00, 0,             0);
    tv[16] = mk(0, 0,             0, 0,             0, 0,            0,   4'hF, 32'h6000_0200, 0, 2'b00, 0,             0);
    tv[17] = mk(0, 0,             0, 0,             1, 32'h5555_5555,0,   4'h0, 32'h6000_0200, 0, 2'b00, 0,             0);
    tv[18] = mk(0, 0,             1, 32'h6000_0300, 0, 0,            1,   4'h0, 32'h6000_0204, 1, 2'b01, 32'h6000_0200, 32'h5555_5555);
    tv[19] = mk(0, 0,             0, 0,             1, 32'h6666_6666,0,   4'hF, 32'h6000_0300, 0, 2'b00, 0,             0);
    tv[20] = mk(0, 0,             0, 0,             0, 0,            0,   4'h0, 32'h6000_0300, 0, 2'b00, 0,             0);
    tv[21] = mk(0, 0,             0, 0,             1, 32'h7777_7777,0,   4'h0, 32'h6000_0300, 0, 2'b00, 0,             0);
    tv[22] = mk(0, 0,             0, 0,             0, 0,            0,   4'hF, 32'h6000_0304, 1, 2'b01, 32'h6000_0300, 32'h7777_7777);

    // reset values
    repeat (2) @(negedge clk);
    #1;
    chk("reset_fq_count", 32'(bus.fq_count), 32'd0);
    chk("reset_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("reset_imem_addr", bus.imem_addr, 32'h6000_0000);

    // table: row i is the i-th cycle after reset release
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      rst = 1'b0;
      bus.commit_redirect_valid = tv[i].crv;
      bus.commit_redirect_pc    = tv[i].cpc;
      bus.decode_redirect_valid = tv[i].drv;
      bus.decode_redirect_pc    = tv[i].dpc;
      bus.imem_resp             = tv[i].resp;
      bus.imem_rdata            = tv[i].rdata;
      bus.inst_ready            = tv[i].rdy;
      #1;
      chk($sformatf("row%0d_rmask", i), 32'(bus.imem_rmask), 32'(tv[i].e_rmask));
      chk($sformatf("row%0d_addr", i), bus.imem_addr, tv[i].e_addr);
      chk($sformatf("row%0d_fq_count", i), 32'(bus.fq_count), 32'(tv[i].e_cnt));
      chk($sformatf("row%0d_valid", i), 32'(bus.inst_valid), 32'(tv[i].e_valid));
      if (tv[i].e_valid[0]) begin
        chk($sformatf("row%0d_pc0", i), bus.inst_pc[31:0], tv[i].e_pc0);
        chk($sformatf("row%0d_inst0", i), bus.inst[31:0], tv[i].e_inst0);
      end
    end

    // reset while the request from row 22 is outstanding
    @(negedge clk);
    bus.commit_redirect_valid = 1'b0;
    bus.decode_redirect_valid = 1'b0;
    bus.imem_resp  = 1'b0;
    bus.inst_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("midreq_reset_fq_count", 32'(bus.fq_count), 32'd0);
    chk("midreq_reset_addr", bus.imem_addr, 32'h6000_0000);

    // abandoned response lands in IDLE right after reset release
    @(negedge clk);
    rst = 1'b0;
    bus.imem_resp  = 1'b1;
    bus.imem_rdata = 32'hBAD0_BAD0;
    #1;
    chk("post_reset_rmask", 32'(bus.imem_rmask), 32'hF);
    chk("post_reset_addr", bus.imem_addr, 32'h6000_0000);
    pend      = (bus.imem_rmask == 4'hF);
    pend_addr = bus.imem_addr;

    step_auto(1'b0);
    chk("idle_resp_ignored", 32'(bus.fq_count), 32'd0);

    // fill to FQ_DEPTH: count c at cycle 2c, full from cycle 16
    issues_full = 0;
    for (int c = 2; c <= 24; c++) begin
      step_auto(1'b0);
      if (c >= 16 && bus.imem_rmask != 4'h0) issues_full++;
    end
    chk("full_fq_count", 32'(bus.fq_count), 32'd8);
    chk("full_no_issue", 32'(issues_full), 32'd0);
    chk("full_pc0", bus.inst_pc[31:0], 32'h6000_0000);
    chk("full_pc1", bus.inst_pc[63:32], 32'h6000_0004);
    chk("full_inst1", bus.inst[63:32], 32'h6000_0004 ^ XOR_K);

    step_auto(1'b1);
    chk("pop_cycle_rmask", 32'(bus.imem_rmask), 32'h0);
    step_auto(1'b0);
    chk("after_pop_fq_count", 32'(bus.fq_count), 32'd6);
    chk("after_pop_rmask", 32'(bus.imem_rmask), 32'hF);
    chk("after_pop_addr", bus.imem_addr, 32'h6000_0020);
    chk("after_pop_pc0", bus.inst_pc[31:0], 32'h6000_0008);

    // continuous stream with a ready pattern; head/tail wrap several times
    exp_pc     = 32'h6000_0008;
    consumed   = 0;
    bad_contig = 0;
    for (int cyc = 0; cyc < 200 && consumed < 26; cyc++) begin
      step_auto(cyc % 3 != 2);
      if (bus.inst_valid == 2'b10) bad_contig++;
      npop = 0;
      for (int l = 0; l < 2; l++) begin
        if (bus.inst_valid[l] && (l == 0 || bus.inst_valid[0])) begin
          chk($sformatf("stream_pc_l%0d", l), bus.inst_pc[l*32 +: 32], exp_pc + 32'(4 * l));
          chk($sformatf("stream_inst_l%0d", l), bus.inst[l*32 +: 32], (exp_pc + 32'(4 * l)) ^ XOR_K);
          npop++;
        end
      end
      if (bus.inst_ready) begin
        exp_pc   = exp_pc + 32'(4 * npop);
        consumed = consumed + npop;
      end
    end
    chk("stream_contiguous", 32'(bad_contig), 32'd0);
    chk("stream_consumed", 32'(consumed >= 26), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
